alu_issue_ctrl: RTL and testbench

Initiator side of the ALU interface. It accepts an operation request over a valid/ready handshake and decodes ALU op and funct into the 3-bit ALU control code. It drives registered operands and control to the combinational ALU, holds them stable for a settle window, then captures y/zero. It returns the result, zero flag and branch decision to the multicycle datapath over a second valid/ready handshake.

---
 rtl/alu_issue_ctrl.sv | 142 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational ALU: decodes op/funct, holds operands
// stable for a settle window, then returns y/zero and the branch decision.
module alu_issue_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned WIDTH         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_alu_op,
    input  logic [5:0]       req_funct,
    input  logic             req_bne,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_taken,
    output logic             rsp_illegal
);

    localparam logic [2:0] CTRL_AND = 3'b000;
    localparam logic [2:0] CTRL_OR  = 3'b001;
    localparam logic [2:0] CTRL_ADD = 3'b010;
    localparam logic [2:0] CTRL_SUB = 3'b110;
    localparam logic [2:0] CTRL_SLT = 3'b111;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Returns {illegal, ctrl}; undecodable requests fall back to ADD so the ALU sees a known code.
    function automatic logic [3:0] decode_ctrl(input logic [1:0] alu_op, input logic [5:0] funct);
        logic [3:0] res;
        case (alu_op)
            2'b00:   res = {1'b0, CTRL_ADD};
            2'b01:   res = {1'b0, CTRL_SUB};
            2'b10: begin
                case (funct)
                    6'b100000: res = {1'b0, CTRL_ADD};
                    6'b100010: res = {1'b0, CTRL_SUB};
                    6'b100100: res = {1'b0, CTRL_AND};
                    6'b100101: res = {1'b0, CTRL_OR};
                    6'b101010: res = {1'b0, CTRL_SLT};
                    default:   res = {1'b1, CTRL_ADD};
                endcase
            end
            default: res = {1'b1, CTRL_ADD};
        endcase
        return res;
    endfunction

    state_t     state_r;
    logic [3:0] cnt_r;
    logic       bne_r;
    logic       branch_r;
    logic       illegal_r;
    logic [3:0] dec_s;
    logic       dec_illegal_s;
    logic [2:0] dec_ctrl_s;

    // Decode of the incoming request, consumed only on the accept edge.
    always_comb begin
        dec_s         = decode_ctrl(req_alu_op, req_funct);
        dec_illegal_s = dec_s[3];
        dec_ctrl_s    = dec_s[2:0];
    end

    // Issue FSM: accept, hold ALU inputs for the settle window, capture, hand back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            bne_r       <= 1'b0;
            branch_r    <= 1'b0;
            illegal_r   <= 1'b0;
            req_ready   <= 1'b1;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctrl    <= CTRL_ADD;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_taken   <= 1'b0;
            rsp_illegal <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        alu_a     <= req_a;
                        alu_b     <= req_b;
                        alu_ctrl  <= dec_ctrl_s;
                        bne_r     <= req_bne;
                        branch_r  <= (req_alu_op == 2'b01);
                        illegal_r <= dec_illegal_s;
                        cnt_r     <= SETTLE_LOAD;
                        req_ready <= 1'b0;
                        state_r   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt_r == 4'd0) begin
                        rsp_result  <= illegal_r ? '0 : alu_y;
                        rsp_zero    <= illegal_r ? 1'b0 : alu_zero;
                        rsp_taken   <= !illegal_r && branch_r && (alu_zero ^ bne_r);
                        rsp_illegal <= illegal_r;
                        rsp_valid   <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Returning to IDLE here means a new request can only be taken next cycle.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    cnt_r     <= 4'd0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU, cycle-level
// reference model with a per-cycle compare, directed literal cases, random traffic.
module tb_alu_issue_ctrl;

    localparam int S = 1;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_alu_op;
    logic [5:0]  req_funct;
    logic        req_bne;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_y;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_taken;
    logic        rsp_illegal;

    int checks   = 0;
    int failures = 0;

    alu_issue_ctrl #(.SETTLE_CYCLES(S), .WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_alu_op (req_alu_op),
        .req_funct  (req_funct),
        .req_bne    (req_bne),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_y      (alu_y),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_taken  (rsp_taken),
        .rsp_illegal(rsp_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU keyed on the control code it is driven with.
    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_y = alu_a & alu_b;
            3'b001:  alu_y = alu_a | alu_b;
            3'b010:  alu_y = alu_a + alu_b;
            3'b110:  alu_y = alu_a - alu_b;
            3'b111:  alu_y = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_y = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_y == 32'd0);
    end

    // Request-level semantics, expressed from the operation meaning rather than control codes.
    function automatic bit spec_illegal(input logic [1:0] op, input logic [5:0] funct);
        if (op == 2'b11) return 1'b1;
        if (op != 2'b10) return 1'b0;
        return !(funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
    endfunction

    function automatic logic [2:0] spec_ctrl(input logic [1:0] op, input logic [5:0] funct);
        if (spec_illegal(op, funct)) return 3'b010;
        if (op == 2'b00) return 3'b010;
        if (op == 2'b01) return 3'b110;
        if (funct == 6'b100010) return 3'b110;
        if (funct == 6'b100100) return 3'b000;
        if (funct == 6'b100101) return 3'b001;
        if (funct == 6'b101010) return 3'b111;
        return 3'b010;
    endfunction

    function automatic logic [31:0] spec_result(input logic [1:0] op, input logic [5:0] funct,
                                                input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (spec_illegal(op, funct)) return 32'd0;
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        if (funct == 6'b100000) return a + b;
        if (funct == 6'b100010) return a - b;
        if (funct == 6'b100100) return a & b;
        if (funct == 6'b100101) return a | b;
        return (sa < sb) ? 32'd1 : 32'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state: one outstanding request with its accept cycle.
    int          cyc   = 0;
    int          m_acc = 0;
    bit          m_known = 1'b0;
    bit          m_out   = 1'b0;
    bit          m_clean = 1'b0;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [2:0]  m_ctrl;
    logic [31:0] m_res;
    bit          m_zero;
    bit          m_taken;
    bit          m_ill;
    logic        m_rspv;

    assign m_rspv = m_out && (cyc >= m_acc + S);

    // Per-cycle compare against the model, then advance the model with this cycle's inputs.
    always @(negedge clk) begin
        if (m_known) begin
            chk("req_ready", 32'(req_ready), 32'(!m_out));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rspv));
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
            if (m_rspv) begin
                chk("rsp_result", rsp_result, m_res);
                chk("rsp_zero", 32'(rsp_zero), 32'(m_zero));
                chk("rsp_taken", 32'(rsp_taken), 32'(m_taken));
                chk("rsp_illegal", 32'(rsp_illegal), 32'(m_ill));
            end else if (m_clean) begin
                chk("rsp_idle", {rsp_result[31:3], rsp_zero, rsp_taken, rsp_illegal} | 32'(rsp_result[2:0]), 32'd0);
            end
        end
        if (!rst_n) begin
            m_known <= 1'b1;
            m_out   <= 1'b0;
            m_clean <= 1'b1;
            m_a     <= 32'd0;
            m_b     <= 32'd0;
            m_ctrl  <= 3'b010;
        end else if (m_known && !m_out && req_valid) begin
            m_out   <= 1'b1;
            m_clean <= 1'b0;
            m_acc   <= cyc + 1;
            m_a     <= req_a;
            m_b     <= req_b;
            m_ctrl  <= spec_ctrl(req_alu_op, req_funct);
            m_ill   <= spec_illegal(req_alu_op, req_funct);
            m_res   <= spec_result(req_alu_op, req_funct, req_a, req_b);
            m_zero  <= !spec_illegal(req_alu_op, req_funct) &&
                       (spec_result(req_alu_op, req_funct, req_a, req_b) == 32'd0);
            m_taken <= (req_alu_op == 2'b01) && ((req_a == req_b) ^ req_bne);
        end else if (m_out && m_rspv && rsp_ready) begin
            m_out <= 1'b0;
        end
        cyc <= cyc + 1;
    end

    // One request with literal expectations; hold = cycles of response backpressure.
    task automatic do_op(input logic [1:0] op, input logic [5:0] funct, input logic bne,
                         input logic [31:0] a, input logic [31:0] b, input int hold,
                         input logic [2:0] e_ctrl, input logic [31:0] e_res,
                         input logic e_zero, input logic e_taken, input logic e_ill);
        bit got;
        int lat;
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_alu_op = op;
        req_funct  = funct;
        req_bne    = bne;
        req_a      = a;
        req_b      = b;
        rsp_ready  = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a     = ~a;
        req_b     = $urandom;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) got = 1'b1;
        end
        if (!got) chk("rsp_timeout", 32'd0, 32'd1);
        chk("latency", 32'(lat), 32'(S + 1));
        for (int k = 0; k <= hold; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                req_valid = k[0];
                req_a     = $urandom;
                @(negedge clk);
            end
            chk("d_req_ready", 32'(req_ready), 32'd0);
            chk("d_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("d_alu_ctrl", 32'(alu_ctrl), 32'(e_ctrl));
            chk("d_rsp_result", rsp_result, e_res);
            chk("d_rsp_zero", 32'(rsp_zero), 32'(e_zero));
            chk("d_rsp_taken", 32'(rsp_taken), 32'(e_taken));
            chk("d_rsp_illegal", 32'(rsp_illegal), 32'(e_ill));
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("d_ready_after", 32'(req_ready), 32'd1);
        chk("d_valid_after", 32'(rsp_valid), 32'd0);
    endtask

    logic [5:0] legal_funct [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_alu_op = 2'b00;
        req_funct  = 6'd0;
        req_bne    = 1'b0;
        req_a      = 32'd0;
        req_b      = 32'd0;
        rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("pin_sub", spec_result(2'b10, 6'b100010, 32'h8, 32'h29), 32'hFFFF_FFDF);
        chk("pin_slt", spec_result(2'b10, 6'b101010, 32'hFFFF_FFFB, 32'hFFFF_FFFD), 32'd1);
        chk("pin_ill", 32'(spec_illegal(2'b10, 6'b000000)), 32'd1);
        chk("pin_ctrl_or", 32'(spec_ctrl(2'b10, 6'b100101)), 32'b001);

        // Reset while EXEC: request discarded, outputs back to reset values.
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_ctrl", 32'(alu_ctrl), 32'b010);
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_alu_op = 2'b10;
        req_funct  = 6'b100010;
        req_a      = 32'h55;
        req_b      = 32'h11;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
            chk("rst_mid_ready", 32'(req_ready), 32'd1);
            chk("rst_mid_ctrl", 32'(alu_ctrl), 32'b010);
        end

        do_op(2'b10, 6'b100010, 1'b0, 32'h8, 32'h29, 0, 3'b110, 32'hFFFF_FFDF, 1'b0, 1'b0, 1'b0);
        do_op(2'b01, 6'b000000, 1'b0, 32'h29, 32'h29, 0, 3'b110, 32'd0, 1'b1, 1'b1, 1'b0);
        do_op(2'b01, 6'b000000, 1'b1, 32'h29, 32'h29, 0, 3'b110, 32'd0, 1'b1, 1'b0, 1'b0);
        do_op(2'b10, 6'b101010, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 0, 3'b111, 32'd0, 1'b1, 1'b0, 1'b0);
        do_op(2'b10, 6'b101010, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFD, 0, 3'b111, 32'd1, 1'b0, 1'b0, 1'b0);
        do_op(2'b10, 6'b101010, 1'b0, 32'h29, 32'hFFFF_FFFF, 0, 3'b111, 32'd0, 1'b1, 1'b0, 1'b0);
        do_op(2'b00, 6'b000000, 1'b1, 32'h10, 32'h20, 5, 3'b010, 32'h30, 1'b0, 1'b0, 1'b0);
        do_op(2'b10, 6'b000000, 1'b1, 32'h5, 32'h7, 0, 3'b010, 32'd0, 1'b0, 1'b0, 1'b1);
        do_op(2'b10, 6'b100100, 1'b0, 32'hF0F0, 32'hFF00, 0, 3'b000, 32'hF000, 1'b0, 1'b0, 1'b0);
        do_op(2'b11, 6'b100000, 1'b0, 32'h1, 32'h2, 0, 3'b010, 32'd0, 1'b0, 1'b0, 1'b1);
        do_op(2'b10, 6'b100101, 1'b0, 32'hF0F0, 32'h0F0F, 2, 3'b001, 32'hFFFF, 1'b0, 1'b0, 1'b0);

        // Random traffic with occasional resets; the model process does the checking.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst_n      = ($urandom_range(0, 199) != 0);
            req_valid  = ($urandom_range(0, 2) != 0);
            rsp_ready  = $urandom_range(0, 1);
            req_alu_op = 2'($urandom_range(0, 3));
            req_funct  = ($urandom_range(0, 4) != 0) ? legal_funct[$urandom_range(0, 4)]
                                                       : 6'($urandom_range(0, 63));
            req_bne    = $urandom_range(0, 1);
            req_a      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            req_b      = ($urandom_range(0, 3) == 0) ? req_a : $urandom;
        end
        @(posedge clk); #1;
        rst_n     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("final_ready", 32'(req_ready), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
